hdu_pipe_ctrl: RTL and testbench

- Parametrised hazard/pipeline control unit for an NSTAGE in-order pipeline. Index 0 = IF, index NSTAGE-1 = WB.
- Generalises per-stage stall, bubble and flush generation to arbitrary depth.
- Adds an in-order register scoreboard with per-register latency counters, replacing the single-cycle load-use request.
- Latches branch-type flushes that arrive during a data-bus wait and replays them when the wait ends.
- Adds a stall watchdog and a stall performance counter.

---
 rtl/hdu_pipe_ctrl_if.sv | 53 +++++
 rtl/hdu_pipe_ctrl.sv | 134 +++++++++++++
 tb/tb_hdu_pipe_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdu_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hdu_pipe_ctrl_if
// Description : Bundle of the pipeline-control request/response signals
//               exchanged between the datapath and hdu_pipe_ctrl.
//               master : the datapath (drives requests, consumes controls)
//               slave  : the hazard/pipeline control unit
//   global_stall   data bus wait, freezes the whole pipeline
//   stall_req      per-stage "cannot complete" requests
//   flush_req      per-stage redirect requests (top bit = trap)
//   id_*           ID-stage operand/destination description
//   stall/bubble/flush  per-stage control outputs
//   sb_hazard, stall_timeout, stall_cycles  status outputs
// Revision    : 1.0 - initial release
// ============================================================================
interface hdu_pipe_ctrl_if #(
    parameter int NSTAGE = 5,
    parameter int NREG   = 32,
    parameter int LATW   = 3
);
    localparam int RW = $clog2(NREG);

    logic              global_stall;
    logic [NSTAGE-1:0] stall_req;
    logic [NSTAGE-1:0] flush_req;
    logic              id_valid;
    logic [RW-1:0]     id_rs1;
    logic [RW-1:0]     id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [RW-1:0]     id_rd;
    logic [LATW-1:0]   id_rd_lat;

    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] bubble;
    logic [NSTAGE-1:0] flush;
    logic              sb_hazard;
    logic              stall_timeout;
    logic [31:0]       stall_cycles;

    modport master (
        output global_stall, stall_req, flush_req, id_valid,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_lat,
        input  stall, bubble, flush, sb_hazard, stall_timeout, stall_cycles
    );

    modport slave (
        input  global_stall, stall_req, flush_req, id_valid,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_lat,
        output stall, bubble, flush, sb_hazard, stall_timeout, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/hdu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hdu_pipe_ctrl
// Description : Hazard/pipeline control for an NSTAGE in-order pipeline
//               (stage 0 = IF, stage NSTAGE-1 = WB). Generates per-stage
//               stall/bubble/flush, tracks in-flight results with a per-
//               register latency scoreboard, defers branch flushes that
//               arrive during a data-bus wait, and provides a stall
//               watchdog plus a stall-cycle counter.
//   clk     clock
//   rst     synchronous active-high reset
//   io_hdu  hdu_pipe_ctrl_if.slave - requests in, controls/status out
// Revision    : 1.0 - initial release
// ============================================================================
module hdu_pipe_ctrl #(
    parameter int NSTAGE  = 5,
    parameter int NREG    = 32,
    parameter int LATW    = 3,
    parameter int TIMEOUT = 1024
) (
    input  wire logic       clk,
    input  wire logic       rst,
    hdu_pipe_ctrl_if.slave  io_hdu
);
    localparam int RW  = $clog2(NREG);
    localparam int GSW = $clog2(TIMEOUT + 1);
    localparam logic [GSW-1:0]    c_TIMEOUT   = GSW'(TIMEOUT);
    // Only branch-type flushes (not stage 0, not trap) can be deferred.
    localparam logic [NSTAGE-1:0] c_PEND_MASK = {1'b0, {(NSTAGE-2){1'b1}}, 1'b0};

    logic [LATW-1:0]   r_cnt [NREG];
    logic [NSTAGE-1:0] r_pend;
    logic [GSW-1:0]    r_gs_cnt;
    logic              r_timeout;
    logic [31:0]       r_stall_cycles;

    logic              w_haz;
    logic              w_trap;
    logic              w_load;
    logic [NSTAGE-1:0] w_req;
    logic [NSTAGE-1:0] w_req_later;   // OR of req[j] for j > k
    logic [NSTAGE-1:0] w_fe;
    logic [NSTAGE-1:0] w_flush;
    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_bubble;
    logic [GSW-1:0]    w_gs_nxt;
    logic              w_unused;

    // flush_req[0] has no earlier stage to kill.
    assign w_unused = io_hdu.flush_req[0];

    assign w_trap = io_hdu.flush_req[NSTAGE-1];

    always_comb begin
        w_haz = io_hdu.id_valid &
                ((io_hdu.id_rs1_used & (io_hdu.id_rs1 != '0) & (r_cnt[io_hdu.id_rs1] != '0)) |
                 (io_hdu.id_rs2_used & (io_hdu.id_rs2 != '0) & (r_cnt[io_hdu.id_rs2] != '0)));

        w_req    = io_hdu.stall_req;
        w_req[1] = io_hdu.stall_req[1] | w_haz;

        // Trap acts immediately; branch flushes wait for the bus to release.
        w_fe = '0;
        w_fe[NSTAGE-1] = w_trap;
        for (int j = 1; j < NSTAGE-1; j++) begin
            w_fe[j] = ~io_hdu.global_stall & (io_hdu.flush_req[j] | r_pend[j]);
        end

        w_flush     = '0;
        w_req_later = '0;
        for (int k = NSTAGE-2; k >= 0; k--) begin
            w_flush[k]     = w_flush[k+1] | w_fe[k+1];
            w_req_later[k] = w_req_later[k+1] | w_req[k+1];
        end

        for (int k = 0; k < NSTAGE; k++) begin
            w_stall[k]  = ~w_flush[k] & (io_hdu.global_stall | w_req_later[k]);
            w_bubble[k] = ~w_flush[k] & ~io_hdu.global_stall & w_req[k] & ~w_req_later[k];
        end

        // ID issues a new scoreboard entry only when it actually advances.
        w_load = io_hdu.id_valid & ~w_stall[1] & ~w_flush[1] & ~w_haz &
                 (io_hdu.id_rd != '0) & (io_hdu.id_rd_lat != '0);

        if (!io_hdu.global_stall) begin
            w_gs_nxt = '0;
        end else if (r_gs_cnt == c_TIMEOUT) begin
            w_gs_nxt = r_gs_cnt;
        end else begin
            w_gs_nxt = r_gs_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_pend         <= '0;
            r_gs_cnt       <= '0;
            r_timeout      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_trap) begin
                    r_cnt[i] <= '0;
                end else if (w_load && (RW'(i) == io_hdu.id_rd)) begin
                    r_cnt[i] <= io_hdu.id_rd_lat;
                end else if (!io_hdu.global_stall && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end

            if (w_trap || !io_hdu.global_stall) begin
                r_pend <= '0;
            end else begin
                r_pend <= r_pend | (io_hdu.flush_req & c_PEND_MASK);
            end

            r_gs_cnt       <= w_gs_nxt;
            r_timeout      <= r_timeout | (w_gs_nxt == c_TIMEOUT);
            r_stall_cycles <= r_stall_cycles + {31'd0, w_stall[0]};
        end
    end

    assign io_hdu.stall         = w_stall;
    assign io_hdu.bubble        = w_bubble;
    assign io_hdu.flush         = w_flush;
    assign io_hdu.sb_hazard     = w_haz;
    assign io_hdu.stall_timeout = r_timeout;
    assign io_hdu.stall_cycles  = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hdu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdu_pipe_ctrl
// Description : Self-checking bench for hdu_pipe_ctrl (NSTAGE=5, TIMEOUT=8).
//               Expected values are queued as each cycle's stimulus is
//               applied and compared once the combinational outputs settle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdu_pipe_ctrl;
    localparam int S_STALL = 0;
    localparam int S_BUB   = 1;
    localparam int S_FLUSH = 2;
    localparam int S_HAZ   = 3;
    localparam int S_TO    = 4;
    localparam int S_CYC   = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q_exp [$];
    int   n_checks;
    int   n_errors;

    hdu_pipe_ctrl_if #(.NSTAGE(5), .NREG(32), .LATW(3)) bus ();

    hdu_pipe_ctrl #(
        .NSTAGE (5),
        .NREG   (32),
        .LATW   (3),
        .TIMEOUT(8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_hdu(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_STALL: return 32'(bus.stall);
            S_BUB:   return 32'(bus.bubble);
            S_FLUSH: return 32'(bus.flush);
            S_HAZ:   return 32'(bus.sb_hazard);
            S_TO:    return 32'(bus.stall_timeout);
            default: return bus.stall_cycles;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        q_exp.push_back(e);
    endtask

    // Let the combinational outputs settle, then retire every queued entry.
    task automatic drain();
        exp_t e;
        #3;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic idle();
        bus.global_stall = 1'b0;
        bus.stall_req    = '0;
        bus.flush_req    = '0;
        bus.id_valid     = 1'b0;
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.id_rs1_used  = 1'b0;
        bus.id_rs2_used  = 1'b0;
        bus.id_rd        = '0;
        bus.id_rd_lat    = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        push("rst_stall", S_STALL, 0);
        push("rst_bubble", S_BUB, 0);
        push("rst_flush", S_FLUSH, 0);
        push("rst_haz", S_HAZ, 0);
        push("rst_timeout", S_TO, 0);
        push("rst_cycles", S_CYC, 0);
        drain();

        // Load-use with latency 1
        @(negedge clk);
        bus.id_valid = 1'b1; bus.id_rd = 5'd5; bus.id_rd_lat = 3'd1;
        push("lu_issue_haz", S_HAZ, 0);
        push("lu_issue_stall", S_STALL, 0);
        drain();
        @(negedge clk);
        bus.id_rd = '0; bus.id_rd_lat = '0; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
        push("lu_dep_haz", S_HAZ, 1);
        push("lu_dep_stall", S_STALL, 32'h01);
        push("lu_dep_bubble", S_BUB, 32'h02);
        push("lu_dep_cycles", S_CYC, 0);
        drain();
        @(negedge clk);
        push("lu_after_haz", S_HAZ, 0);
        push("lu_after_stall", S_STALL, 0);
        push("lu_after_cycles", S_CYC, 1);
        drain();

        // Latency 3 on rs2: exactly three hazard cycles
        @(negedge clk);
        bus.id_rs1_used = 1'b0; bus.id_rd = 5'd9; bus.id_rd_lat = 3'd3;
        push("l3_issue_haz", S_HAZ, 0);
        drain();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.id_rd = '0; bus.id_rd_lat = '0; bus.id_rs2 = 5'd9; bus.id_rs2_used = 1'b1;
            push("l3_dep_haz", S_HAZ, 1);
            push("l3_dep_bubble", S_BUB, 32'h02);
            drain();
        end
        @(negedge clk);
        push("l3_end_haz", S_HAZ, 0);
        push("l3_end_cycles", S_CYC, 4);
        drain();

        // Register 0 and latency 0 never create entries
        @(negedge clk);
        bus.id_rs2_used = 1'b0; bus.id_rd = 5'd0; bus.id_rd_lat = 3'd3;
        push("r0_issue_haz", S_HAZ, 0);
        drain();
        @(negedge clk);
        bus.id_rd = 5'd7; bus.id_rd_lat = 3'd0; bus.id_rs1 = 5'd0; bus.id_rs1_used = 1'b1;
        push("r0_read_haz", S_HAZ, 0);
        drain();
        @(negedge clk);
        bus.id_rd = 5'd0; bus.id_rs2 = 5'd7; bus.id_rs2_used = 1'b1;
        push("lat0_read_haz", S_HAZ, 0);
        push("lat0_cycles", S_CYC, 4);
        drain();

        // Branch flush deferred across a 3-cycle bus wait
        @(negedge clk);
        idle();
        bus.global_stall = 1'b1; bus.flush_req = 5'b00100;
        push("defer_c1_flush", S_FLUSH, 0);
        push("defer_c1_stall", S_STALL, 32'h1f);
        push("defer_c1_bubble", S_BUB, 0);
        drain();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.flush_req = '0;
            push("defer_wait_flush", S_FLUSH, 0);
            push("defer_wait_stall", S_STALL, 32'h1f);
            drain();
        end
        @(negedge clk);
        bus.global_stall = 1'b0;
        push("defer_replay_flush", S_FLUSH, 32'h03);
        push("defer_replay_stall", S_STALL, 0);
        push("defer_replay_bubble", S_BUB, 0);
        drain();
        @(negedge clk);
        push("defer_done_flush", S_FLUSH, 0);
        push("defer_done_cycles", S_CYC, 7);
        drain();

        // Trap under bus wait clears a live scoreboard entry
        @(negedge clk);
        bus.id_valid = 1'b1; bus.id_rd = 5'd3; bus.id_rd_lat = 3'd2;
        push("trap_issue_haz", S_HAZ, 0);
        drain();
        @(negedge clk);
        bus.id_valid = 1'b0; bus.id_rd = '0; bus.id_rd_lat = '0;
        bus.global_stall = 1'b1; bus.flush_req = 5'b10000;
        push("trap_flush", S_FLUSH, 32'h0f);
        push("trap_stall", S_STALL, 32'h10);
        push("trap_bubble", S_BUB, 0);
        drain();
        @(negedge clk);
        bus.global_stall = 1'b0; bus.flush_req = '0;
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd3; bus.id_rs1_used = 1'b1;
        push("trap_after_haz", S_HAZ, 0);
        push("trap_after_flush", S_FLUSH, 0);
        push("trap_after_stall", S_STALL, 0);
        push("trap_after_cycles", S_CYC, 7);
        drain();

        // Later request dominates; flush dominates everything
        @(negedge clk);
        idle();
        bus.stall_req = 5'b01100;
        push("prio_stall", S_STALL, 32'h07);
        push("prio_bubble", S_BUB, 32'h08);
        drain();
        @(negedge clk);
        bus.flush_req = 5'b10000;
        push("prio_trap_stall", S_STALL, 0);
        push("prio_trap_bubble", S_BUB, 0);
        push("prio_trap_flush", S_FLUSH, 32'h0f);
        drain();
        @(negedge clk);
        idle();
        push("prio_cycles", S_CYC, 8);
        drain();

        // Watchdog trips after exactly TIMEOUT stalled cycles
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.global_stall = 1'b1;
            push("wd_early_timeout", S_TO, 0);
            drain();
        end
        @(negedge clk);
        bus.global_stall = 1'b0;
        push("wd_trip_timeout", S_TO, 1);
        push("wd_cycles", S_CYC, 16);
        drain();
        @(negedge clk);
        push("wd_sticky_timeout", S_TO, 1);
        drain();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push("wd_rst_timeout", S_TO, 0);
        push("wd_rst_cycles", S_CYC, 0);
        push("wd_rst_stall", S_STALL, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
